linebuffer_window9: RTL and testbench

Streaming 9x9 window generator for the logistic-regression datapath. It accepts one 7-bit pixel per handshake in raster order. It holds the previous 8 image rows in line buffers and presents the 81-pixel window ending at the current pixel, flattened to match the 81-entry window input of the inner-product stage. Each complete window is presented once, with a valid/ready handshake toward the inner-product/sigmoid stage.

---
 rtl/lr_pkg.sv | 18 +
 rtl/linebuffer_rowmem.sv | 36 +++
 rtl/linebuffer_window9.sv | 132 +++++++++++++
 tb/tb_linebuffer_window9.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lr_pkg.sv
// Shared definitions for the logistic-regression datapath: pixel width,
// window geometry, default image size and the window flattening helper.
package lr_pkg;

    localparam int PIX_W         = 7;
    localparam int WIN           = 9;
    localparam int WIN_N         = WIN * WIN;
    localparam int IMG_W_DEFAULT = 28;
    localparam int IMG_H_DEFAULT = 28;

    typedef logic [PIX_W-1:0] pix_t;

    // Flat element index of window row r, column c (row-major, r=0 on top).
    function automatic int win_idx(input int r, input int c);
        return r * WIN + c;
    endfunction

endpackage

// File: rtl/linebuffer_rowmem.sv
// Column-shift memory holding the previous WIN-1 image rows.
// One column is read and then shifted up by one row per accepted pixel.
// The storage is deliberately left without reset.
module linebuffer_rowmem
    import lr_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int COL_W = $clog2(IMG_W)
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [COL_W-1:0]        col,
    input  pix_t                    pix,
    output pix_t [WIN-2:0]          col_o
);

    pix_t mem [0:WIN-2][0:IMG_W-1];

    // Present the stored column at the current position, oldest row at index 0.
    always_comb begin
        for (int i = 0; i < WIN - 1; i++) begin
            col_o[i] = mem[i][col];
        end
    end

    // Shift the addressed column up one row and store the new pixel at the bottom.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < WIN - 2; i++) begin
                mem[i][col] <= mem[i+1][col];
            end
            mem[WIN-2][col] <= pix;
        end
    end

endmodule

// File: rtl/linebuffer_window9.sv
// Streaming 9x9 window generator: raster-order pixels in, one flattened
// window out for each position where a full 9x9 neighbourhood exists.
module linebuffer_window9
    import lr_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int IMG_H = IMG_H_DEFAULT,
    localparam int ROW_W = $clog2(IMG_H),
    localparam int COL_W = $clog2(IMG_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PIX_W-1:0]         pix_i,
    input  logic                     pix_sof_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [WIN_N*PIX_W-1:0]   win_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ROW_W-1:0]         out_row_o,
    output logic [COL_W-1:0]         out_col_o,
    output logic                     frame_done_o
);

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;
    logic             accept;
    logic             last_col;
    logic             last_row;
    logic             complete;
    pix_t [WIN-2:0]   lb_col;
    pix_t             col_vec [0:WIN-1];
    pix_t             win [0:WIN-1][0:WIN-1];

    // A held window blocks new pixels unless it is being taken this cycle.
    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    // Start-of-frame forces the accepted pixel to position (0,0).
    assign cur_row  = pix_sof_i ? '0 : row;
    assign cur_col  = pix_sof_i ? '0 : col;
    assign last_col = (cur_col == COL_W'(IMG_W - 1));
    assign last_row = (cur_row == ROW_W'(IMG_H - 1));
    assign complete = (cur_row >= ROW_W'(WIN - 1)) && (cur_col >= COL_W'(WIN - 1));

    linebuffer_rowmem #(
        .IMG_W (IMG_W),
        .COL_W (COL_W)
    ) u_rowmem (
        .clk   (clk),
        .wr_en (accept),
        .col   (cur_col),
        .pix   (pix_i),
        .col_o (lb_col)
    );

    // Column entering the window: eight buffered rows on top, the new pixel last.
    always_comb begin
        for (int i = 0; i < WIN - 1; i++) begin
            col_vec[i] = lb_col[i];
        end
        col_vec[WIN-1] = pix_i;
    end

    // Advance the raster position of the next pixel to accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : cur_row + ROW_W'(1);
            end else begin
                col <= cur_col + COL_W'(1);
                row <= cur_row;
            end
        end
    end

    // Shift the window left by one column and load the new right-hand column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][WIN-1] <= col_vec[r];
            end
        end
    end

    // Output handshake, window coordinates and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o  <= 1'b0;
            out_row_o    <= '0;
            out_col_o    <= '0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= accept && last_row && last_col;
            if (accept) begin
                out_valid_o <= complete;
                if (complete) begin
                    out_row_o <= cur_row - ROW_W'(WIN - 1);
                    out_col_o <= cur_col - COL_W'(WIN - 1);
                end
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

    // Flatten the window array into the inner-product input ordering.
    always_comb begin
        win_o = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                win_o[win_idx(r, c)*PIX_W +: PIX_W] = win[r][c];
            end
        end
    end

endmodule

// File: tb/tb_linebuffer_window9.sv
// Testbench for linebuffer_window9: a per-cycle reference model keeps the
// image written so far and derives each expected window directly from it.
module tb_linebuffer_window9;
    import lr_pkg::*;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int WB = WIN_N * PIX_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [PIX_W-1:0] pix_i = '0;
    logic             pix_sof_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [WB-1:0]    win_o;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic [4:0]       out_row_o;
    logic [4:0]       out_col_o;
    logic             frame_done_o;

    linebuffer_window9 #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_i        (pix_i),
        .pix_sof_i    (pix_sof_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .win_o        (win_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_row_o    (out_row_o),
        .out_col_o    (out_col_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [PIX_W-1:0] img [0:H-1][0:W-1];
    bit               m_valid;
    logic [WB-1:0]    m_win;
    int               m_row, m_col;
    bit               m_fd;
    int               pos_r, pos_c;
    bit               stall_prev;
    logic [WB-1:0]    stall_win;
    logic [4:0]       stall_row, stall_col;
    int               stall_seen;
    int               win_cnt, fd_cnt, last_row, last_col;
    logic [WB-1:0]    cap_win;
    bit               bp;
    int               n_pass, n_total;

    function automatic logic [PIX_W-1:0] ramp(input int r, input int c, input int off);
        return PIX_W'((r * W + c + off) % 128);
    endfunction

    // One clock of the reference model: compare at the falling edge, then
    // predict what the coming rising edge does.
    task automatic run_cycle(output bit acc);
        int R, C;
        acc = 1'b0;
        @(negedge clk);
        if (!rst_n) begin
            n_total++;
            if (out_valid_o !== 1'b0) $display("[TB] FAIL valid_in_reset got %b want 0", out_valid_o);
            else n_pass++;
            m_valid = 0; m_fd = 0; pos_r = 0; pos_c = 0; stall_prev = 0;
        end else begin
            n_total++;
            if (out_valid_o !== m_valid) $display("[TB] FAIL out_valid got %b want %b", out_valid_o, m_valid);
            else n_pass++;
            if (m_valid) begin
                n_total++;
                if (win_o !== m_win) $display("[TB] FAIL window got %h want %h", win_o, m_win);
                else n_pass++;
                n_total++;
                if (out_row_o !== 5'(m_row) || out_col_o !== 5'(m_col))
                    $display("[TB] FAIL win_pos got (%0d,%0d) want (%0d,%0d)", out_row_o, out_col_o, m_row, m_col);
                else n_pass++;
            end
            n_total++;
            if (frame_done_o !== m_fd) $display("[TB] FAIL frame_done got %b want %b", frame_done_o, m_fd);
            else n_pass++;
            n_total++;
            if (in_ready_o !== (!m_valid || out_ready_i))
                $display("[TB] FAIL in_ready got %b want %b", in_ready_o, (!m_valid || out_ready_i));
            else n_pass++;
            if (stall_prev) begin
                n_total++;
                if (win_o !== stall_win || out_row_o !== stall_row || out_col_o !== stall_col)
                    $display("[TB] FAIL stall_stable got (%0d,%0d) want (%0d,%0d)", out_row_o, out_col_o, stall_row, stall_col);
                else n_pass++;
            end
            if (frame_done_o === 1'b1) fd_cnt++;
            if (m_valid && out_ready_i) begin
                win_cnt++;
                last_row = m_row;
                last_col = m_col;
                if (m_row == 0 && m_col == 0) cap_win = win_o;
            end
            stall_prev = m_valid && !out_ready_i;
            if (stall_prev) stall_seen++;
            stall_win = win_o;
            stall_row = out_row_o;
            stall_col = out_col_o;

            acc  = in_valid_i && (!m_valid || out_ready_i);
            m_fd = 0;
            if (acc) begin
                R = pix_sof_i ? 0 : pos_r;
                C = pix_sof_i ? 0 : pos_c;
                img[R][C] = pix_i;
                if (R >= 8 && C >= 8) begin
                    m_valid = 1;
                    m_row = R - 8;
                    m_col = C - 8;
                    for (int r = 0; r < WIN; r++)
                        for (int c = 0; c < WIN; c++)
                            m_win[(r*WIN+c)*PIX_W +: PIX_W] = img[R-8+r][C-8+c];
                end else begin
                    m_valid = 0;
                end
                m_fd = (R == H - 1) && (C == W - 1);
                if (C == W - 1) begin
                    pos_c = 0;
                    pos_r = (R == H - 1) ? 0 : R + 1;
                end else begin
                    pos_r = R;
                    pos_c = C + 1;
                end
            end else if (out_ready_i) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        out_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic drive_pixel(input logic [PIX_W-1:0] p, input bit sof);
        bit acc;
        bit done;
        done = 0;
        in_valid_i = 1'b1;
        pix_i      = p;
        pix_sof_i  = sof;
        for (int i = 0; i < 100 && !done; i++) begin
            run_cycle(acc);
            done = acc;
        end
        if (!done) begin
            n_total++;
            $display("[TB] FAIL accept_timeout got no accept want accept within 100 cycles");
        end
        in_valid_i = 1'b0;
        pix_sof_i  = 1'b0;
    endtask

    task automatic drive_frame(input int off, input bit sof_first, input int gap, input bit rnd, input int npix);
        bit acc;
        for (int idx = 0; idx < npix; idx++) begin
            drive_pixel(rnd ? PIX_W'($urandom) : ramp(idx / W, idx % W, off), sof_first && idx == 0);
            for (int g = 0; g < gap; g++) run_cycle(acc);
        end
    endtask

    task automatic drain();
        bit acc;
        in_valid_i  = 1'b0;
        bp          = 0;
        out_ready_i = 1'b1;
        repeat (4) run_cycle(acc);
    endtask

    task automatic test_reset();
        bit acc;
        rst_n = 1'b0;
        run_cycle(acc);
        run_cycle(acc);
        rst_n = 1'b1;
        run_cycle(acc);
        n_total++;
        if (win_o !== '0) $display("[TB] FAIL reset_window got %h want 0", win_o);
        else n_pass++;
        n_total++;
        if (out_row_o !== 5'd0 || out_col_o !== 5'd0)
            $display("[TB] FAIL reset_pos got (%0d,%0d) want (0,0)", out_row_o, out_col_o);
        else n_pass++;
    endtask

    task automatic test_ramp();
        logic [WB-1:0] exp_w;
        win_cnt = 0; fd_cnt = 0;
        drive_frame(0, 1, 0, 0, W * H);
        drain();
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                exp_w[(r*WIN+c)*PIX_W +: PIX_W] = PIX_W'((r * 28 + c) % 128);
        n_total++;
        if (win_cnt != 400) $display("[TB] FAIL ramp_count got %0d want 400", win_cnt);
        else n_pass++;
        n_total++;
        if (cap_win !== exp_w) $display("[TB] FAIL ramp_first_window got %h want %h", cap_win, exp_w);
        else n_pass++;
        n_total++;
        if (last_row != 19 || last_col != 19)
            $display("[TB] FAIL ramp_last_pos got (%0d,%0d) want (19,19)", last_row, last_col);
        else n_pass++;
        n_total++;
        if (fd_cnt != 1) $display("[TB] FAIL ramp_frame_done got %0d want 1", fd_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        win_cnt = 0; stall_seen = 0;
        bp = 1;
        drive_frame(0, 1, 0, 1, W * H);
        drain();
        n_total++;
        if (win_cnt != 400) $display("[TB] FAIL bp_count got %0d want 400", win_cnt);
        else n_pass++;
        n_total++;
        if (stall_seen == 0) $display("[TB] FAIL bp_stalls got %0d want >0", stall_seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [WB-1:0] exp_w;
        win_cnt = 0;
        drive_frame(0, 1, 0, 0, W * H);
        drive_frame(64, 1, 0, 0, W * H);
        drain();
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                exp_w[(r*WIN+c)*PIX_W +: PIX_W] = PIX_W'((r * 28 + c + 64) % 128);
        n_total++;
        if (win_cnt != 800) $display("[TB] FAIL b2b_count got %0d want 800", win_cnt);
        else n_pass++;
        n_total++;
        if (cap_win !== exp_w) $display("[TB] FAIL b2b_frame2_window got %h want %h", cap_win, exp_w);
        else n_pass++;
    endtask

    task automatic test_resync();
        int first_valid;
        logic [4:0] fr, fc;
        first_valid = -1;
        fr = '1; fc = '1;
        drive_frame(0, 1, 0, 0, 12 * W + 5);
        win_cnt = 0;
        for (int idx = 0; idx < W * H; idx++) begin
            drive_pixel(ramp(idx / W, idx % W, 0), idx == 0);
            if (first_valid < 0 && out_valid_o === 1'b1) begin
                first_valid = idx + 1;
                fr = out_row_o;
                fc = out_col_o;
            end
        end
        drain();
        n_total++;
        if (first_valid != 8 * W + 9) $display("[TB] FAIL resync_latency got %0d want %0d", first_valid, 8 * W + 9);
        else n_pass++;
        n_total++;
        if (fr !== 5'd0 || fc !== 5'd0) $display("[TB] FAIL resync_first_pos got (%0d,%0d) want (0,0)", fr, fc);
        else n_pass++;
        n_total++;
        if (win_cnt != 400) $display("[TB] FAIL resync_count got %0d want 400", win_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit acc;
        drive_frame(0, 1, 0, 0, 15 * W + 3);
        rst_n = 1'b0;
        repeat (3) run_cycle(acc);
        rst_n = 1'b1;
        win_cnt = 0; fd_cnt = 0;
        drive_frame(32, 0, 0, 0, W * H);
        drain();
        n_total++;
        if (win_cnt != 400) $display("[TB] FAIL reset_mid_count got %0d want 400", win_cnt);
        else n_pass++;
        n_total++;
        if (fd_cnt != 1) $display("[TB] FAIL reset_mid_frame_done got %0d want 1", fd_cnt);
        else n_pass++;
    endtask

    task automatic test_gapped();
        win_cnt = 0; fd_cnt = 0;
        drive_frame(0, 1, 2, 0, W * H);
        drain();
        n_total++;
        if (win_cnt != 400) $display("[TB] FAIL gapped_count got %0d want 400", win_cnt);
        else n_pass++;
        n_total++;
        if (last_row != 19 || last_col != 19)
            $display("[TB] FAIL gapped_last_pos got (%0d,%0d) want (19,19)", last_row, last_col);
        else n_pass++;
        n_total++;
        if (fd_cnt != 1) $display("[TB] FAIL gapped_frame_done got %0d want 1", fd_cnt);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0; bp = 0;
        stall_seen = 0; win_cnt = 0; fd_cnt = 0;
        last_row = -1; last_col = -1;
        cap_win = '0; m_win = '0; stall_win = '0;
        stall_row = '0; stall_col = '0;
        m_valid = 0; m_fd = 0; pos_r = 0; pos_c = 0; stall_prev = 0;
        #1;
        $display("[TB] starting linebuffer_window9 bench");
        test_reset();
        test_ramp();
        test_backpressure();
        test_back_to_back();
        test_resync();
        test_reset_mid();
        test_gapped();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
